// File: rtl/sdram_rw_arbiter_pkg.sv
// Shared command/state encodings and the grant-selection helper for the
// SDRAM read/write arbiter.
package sdram_pkg;

  typedef enum logic [1:0] {
    CMD_REF = 2'd0,
    CMD_WR  = 2'd1,
    CMD_RD  = 2'd2
  } cmd_type_e;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_BUSY  = 2'd3
  } state_e;

  typedef struct packed {
    logic      vld;
    cmd_type_e typ;
  } grant_t;

  // Refresh always wins; on a write/read tie the side not served last goes.
  function automatic grant_t arb_pick(input logic ref_pend, input logic wr_ok,
                                      input logic rd_ok, input logic last_rd);
    grant_t g;
    g.vld = 1'b1;
    g.typ = CMD_REF;
    if (ref_pend)                              g.typ = CMD_REF;
    else if (wr_ok && (!rd_ok || last_rd))     g.typ = CMD_WR;
    else if (rd_ok)                            g.typ = CMD_RD;
    else                                       g.vld = 1'b0;
    return g;
  endfunction

endpackage

// File: rtl/sdram_rw_arbiter_if.sv
// Command handshake between the arbiter (master) and the SDRAM command engine.
interface sdram_rw_arbiter_if #(
  parameter int ADDR_W = 22,
  parameter int LEN_W  = 9
);
  import sdram_pkg::*;

  logic              cmd_req;
  cmd_type_e         cmd_type;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              cmd_ack;
  logic              cmd_done;

  modport master (output cmd_req, cmd_type, cmd_addr, cmd_len,
                  input  cmd_ack, cmd_done);
  modport slave  (input  cmd_req, cmd_type, cmd_addr, cmd_len,
                  output cmd_ack, cmd_done);
endinterface

// File: rtl/sdram_rw_arbiter_addr_ptr.sv
// Per-path frame pointer: advances by burst length on completion, wraps to the
// start address with a one-cycle frame pulse, and defers loads while in flight.
module sdram_addr_ptr #(
  parameter int ADDR_W = 22,
  parameter int LEN_W  = 9
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W-1:0] max_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              load_i,
  input  logic              busy_i,
  input  logic              fin_i,
  output logic [ADDR_W-1:0] ptr_o,
  output logic              frame_done_o
);
  localparam int AW1 = ADDR_W + 1;

  logic [ADDR_W-1:0] ptr_q;
  logic              pend_q;
  logic              frame_q;
  logic [ADDR_W:0]   sum;
  logic              wrap;

  // One extra bit so a sum past the top of the address space still compares high.
  assign sum  = {1'b0, ptr_q} + AW1'(len_i);
  assign wrap = sum >= {1'b0, max_addr_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q   <= start_addr_i;
      pend_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      frame_q <= 1'b0;
      if (fin_i) begin
        pend_q <= 1'b0;
        if (pend_q || load_i) begin
          ptr_q <= start_addr_i;
        end else if (wrap) begin
          ptr_q   <= start_addr_i;
          frame_q <= 1'b1;
        end else begin
          ptr_q <= sum[ADDR_W-1:0];
        end
      end else if (load_i) begin
        if (busy_i) pend_q <= 1'b1;
        else        ptr_q  <= start_addr_i;
      end
    end
  end

  assign ptr_o        = ptr_q;
  assign frame_done_o = frame_q;

endmodule

// File: rtl/sdram_rw_arbiter.sv
// Arbitrates refresh, frame-write and frame-read bursts onto a single SDRAM
// command engine, with periodic refresh scheduling and per-path frame pointers.
module sdram_rw_arbiter
  import sdram_pkg::*;
#(
  parameter int ADDR_W        = 22,
  parameter int LEN_W         = 9,
  parameter int LVL_W         = 11,
  parameter int RD_FIFO_DEPTH = 1024,
  parameter int REF_PERIOD    = 780
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic [LEN_W-1:0]  wr_len,
  input  logic [LEN_W-1:0]  rd_len,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] wr_max_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [ADDR_W-1:0] rd_max_addr,
  input  logic              wr_load,
  input  logic              rd_load,
  input  logic [LVL_W-1:0]  wr_fifo_used,
  input  logic [LVL_W-1:0]  rd_fifo_used,
  input  logic              rd_enable,
  sdram_rw_arbiter_if.master cmd,
  output logic              frame_write_done,
  output logic              frame_read_done,
  output logic              ref_overrun
);
  localparam int CW     = 32;
  localparam int RCW    = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
  localparam int NPATH  = 2;  // path 0 = write, path 1 = read

  state_e            state_q;
  logic              cmd_req_q;
  cmd_type_e         cmd_type_q;
  logic [ADDR_W-1:0] cmd_addr_q, addr_d;
  logic [LEN_W-1:0]  cmd_len_q, len_d;
  logic              last_rd_q;
  logic [RCW-1:0]    ref_cnt_q;
  logic              ref_pend_q, ref_ovr_q;

  logic wr_ok, rd_ok, in_cmd, fin, ref_ack, ref_wrap;
  grant_t gnt_d;

  logic [NPATH-1:0][ADDR_W-1:0] start_a, max_a, ptr;
  logic [NPATH-1:0]             load_v, busy_v, fin_v, frame_v;

  assign wr_ok = CW'(wr_fifo_used) >= CW'(wr_len);
  assign rd_ok = rd_enable && (CW'(rd_fifo_used) + CW'(rd_len) <= CW'(RD_FIFO_DEPTH));

  assign in_cmd   = (state_q == ST_ISSUE) || (state_q == ST_BUSY);
  // Completion counts in ISSUE only alongside the ack, so a done never precedes acceptance.
  assign fin      = cmd.cmd_done && (((state_q == ST_ISSUE) && cmd.cmd_ack) || (state_q == ST_BUSY));
  assign ref_ack  = (state_q == ST_ISSUE) && cmd.cmd_ack && (cmd_type_q == CMD_REF);
  assign ref_wrap = (state_q != ST_INIT) && (ref_cnt_q == RCW'(REF_PERIOD - 1));

  always_comb begin
    gnt_d  = arb_pick(ref_pend_q, wr_ok, rd_ok, last_rd_q);
    addr_d = '0;
    len_d  = '0;
    case (gnt_d.typ)
      CMD_WR:  begin addr_d = ptr[0]; len_d = wr_len; end
      CMD_RD:  begin addr_d = ptr[1]; len_d = rd_len; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      cmd_req_q  <= 1'b0;
      cmd_type_q <= CMD_REF;
      cmd_addr_q <= '0;
      cmd_len_q  <= '0;
      last_rd_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_INIT: if (init_done) state_q <= ST_IDLE;
        ST_IDLE: begin
          if (gnt_d.vld) begin
            state_q    <= ST_ISSUE;
            cmd_req_q  <= 1'b1;
            cmd_type_q <= gnt_d.typ;
            cmd_addr_q <= addr_d;
            cmd_len_q  <= len_d;
            if (gnt_d.typ != CMD_REF) last_rd_q <= (gnt_d.typ == CMD_RD);
          end
        end
        ST_ISSUE: begin
          if (cmd.cmd_ack) begin
            cmd_req_q <= 1'b0;
            state_q   <= cmd.cmd_done ? ST_IDLE : ST_BUSY;
          end
        end
        ST_BUSY: if (cmd.cmd_done) state_q <= ST_IDLE;
        default: state_q <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt_q  <= '0;
      ref_pend_q <= 1'b0;
      ref_ovr_q  <= 1'b0;
    end else begin
      if (state_q != ST_INIT) ref_cnt_q <= ref_wrap ? '0 : ref_cnt_q + 1'b1;
      // A fresh request on the same edge as an ack must survive, hence wrap first.
      if (ref_wrap) begin
        ref_pend_q <= 1'b1;
        if (ref_pend_q && !ref_ack) ref_ovr_q <= 1'b1;
      end else if (ref_ack) begin
        ref_pend_q <= 1'b0;
      end
    end
  end

  assign start_a = {rd_addr, wr_addr};
  assign max_a   = {rd_max_addr, wr_max_addr};
  assign load_v  = {rd_load, wr_load};
  assign busy_v  = {in_cmd && (cmd_type_q == CMD_RD), in_cmd && (cmd_type_q == CMD_WR)};
  assign fin_v   = {fin && (cmd_type_q == CMD_RD), fin && (cmd_type_q == CMD_WR)};

  for (genvar p = 0; p < NPATH; p++) begin : g_path
    sdram_addr_ptr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_ptr (
      .clk         (clk),
      .rst         (rst),
      .start_addr_i(start_a[p]),
      .max_addr_i  (max_a[p]),
      .len_i       (cmd_len_q),
      .load_i      (load_v[p]),
      .busy_i      (busy_v[p]),
      .fin_i       (fin_v[p]),
      .ptr_o       (ptr[p]),
      .frame_done_o(frame_v[p])
    );
  end

  assign cmd.cmd_req      = cmd_req_q;
  assign cmd.cmd_type     = cmd_type_q;
  assign cmd.cmd_addr     = cmd_addr_q;
  assign cmd.cmd_len      = cmd_len_q;
  assign frame_write_done = frame_v[0];
  assign frame_read_done  = frame_v[1];
  assign ref_overrun      = ref_ovr_q;

endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// Directed bench: init gating, alternation, refresh/overrun, frame wrap,
// deferred load and mid-command reset, with hand-computed expectations.
module tb_sdram_rw_arbiter;
  import sdram_pkg::*;

  localparam int AW = 22;
  localparam int LW = 9;
  localparam int VW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, rst2 = 1'b1, init_done = 1'b0;
  logic [LW-1:0] wr_len = 9'd256, rd_len = 9'd256;
  logic [AW-1:0] wr_addr = '0, wr_max_addr = 22'h100000, rd_addr = '0, rd_max_addr = 22'h100000;
  logic          wr_load = 1'b0, rd_load = 1'b0, rd_enable = 1'b0;
  logic [VW-1:0] wr_fifo_used = '0, rd_fifo_used = '0;
  logic          sel = 1'b0, eng_ack = 1'b0, eng_done = 1'b0;
  logic          fw_m, fr_m, ovr_m, fw_r, fr_r, ovr_r;

  sdram_rw_arbiter_if #(.ADDR_W(AW), .LEN_W(LW)) m_if ();
  sdram_rw_arbiter_if #(.ADDR_W(AW), .LEN_W(LW)) r_if ();

  assign m_if.cmd_ack  = eng_ack  & ~sel;
  assign m_if.cmd_done = eng_done & ~sel;
  assign r_if.cmd_ack  = eng_ack  &  sel;
  assign r_if.cmd_done = eng_done &  sel;

  sdram_rw_arbiter u_dut (
    .clk(clk), .rst(rst), .init_done(init_done), .wr_len(wr_len), .rd_len(rd_len),
    .wr_addr(wr_addr), .wr_max_addr(wr_max_addr), .rd_addr(rd_addr), .rd_max_addr(rd_max_addr),
    .wr_load(wr_load), .rd_load(rd_load), .wr_fifo_used(wr_fifo_used), .rd_fifo_used(rd_fifo_used),
    .rd_enable(rd_enable), .cmd(m_if), .frame_write_done(fw_m), .frame_read_done(fr_m),
    .ref_overrun(ovr_m));

  sdram_rw_arbiter #(.REF_PERIOD(20)) u_ref (
    .clk(clk), .rst(rst2), .init_done(init_done), .wr_len(wr_len), .rd_len(rd_len),
    .wr_addr(wr_addr), .wr_max_addr(wr_max_addr), .rd_addr(rd_addr), .rd_max_addr(rd_max_addr),
    .wr_load(wr_load), .rd_load(rd_load), .wr_fifo_used(wr_fifo_used), .rd_fifo_used(rd_fifo_used),
    .rd_enable(rd_enable), .cmd(r_if), .frame_write_done(fw_r), .frame_read_done(fr_r),
    .ref_overrun(ovr_r));

  logic          obs_req;
  logic [1:0]    obs_type;
  logic [AW-1:0] obs_addr;
  logic [LW-1:0] obs_len;
  assign obs_req  = sel ? r_if.cmd_req  : m_if.cmd_req;
  assign obs_type = sel ? r_if.cmd_type : m_if.cmd_type;
  assign obs_addr = sel ? r_if.cmd_addr : m_if.cmd_addr;
  assign obs_len  = sel ? r_if.cmd_len  : m_if.cmd_len;

  int fw_cnt = 0, fr_cnt = 0;
  always @(posedge clk) begin
    if (fw_m) fw_cnt <= fw_cnt + 1;
    if (fr_m) fr_cnt <= fr_cnt + 1;
  end

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Engine model: wait for a request, ack after ack_dly cycles, done done_dly
  // cycles after the ack (0 = same cycle); optionally pulse rd_load while busy.
  task automatic issue(input int ack_dly, input int done_dly, input bit mid_rload,
                       output logic [1:0] t, output logic [AW-1:0] a, output logic [LW-1:0] l);
    int w = 0;
    while (!obs_req && w < 300) begin @(negedge clk); w++; end
    chk("req_seen", 32'(obs_req), 32'd1);
    t = obs_type; a = obs_addr; l = obs_len;
    if (!obs_req) return;
    repeat (ack_dly) @(negedge clk);
    eng_ack = 1'b1;
    if (done_dly == 0) eng_done = 1'b1;
    @(negedge clk);
    eng_ack = 1'b0; eng_done = 1'b0;
    chk("req_drop", 32'(obs_req), 32'd0);
    if (done_dly > 0) begin
      if (mid_rload) begin rd_load = 1'b1; @(negedge clk); rd_load = 1'b0; end
      repeat (done_dly - 1 - (mid_rload ? 1 : 0)) @(negedge clk);
      eng_done = 1'b1;
      @(negedge clk);
      eng_done = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  logic [1:0]    t;
  logic [AW-1:0] a;
  logic [LW-1:0] l;
  bit            seen;
  int            base;

  initial begin
    // init gating and reset values
    wr_fifo_used = 11'd300;
    repeat (3) @(negedge clk);
    chk("rst_req",  32'(m_if.cmd_req),  32'd0);
    chk("rst_type", 32'(m_if.cmd_type), 32'd0);
    chk("rst_addr", 32'(m_if.cmd_addr), 32'd0);
    chk("rst_len",  32'(m_if.cmd_len),  32'd0);
    chk("rst_frm",  32'({fw_m, fr_m}),  32'd0);
    chk("rst_ovr",  32'(ovr_m),         32'd0);
    rst = 1'b0;
    seen = 1'b0;
    repeat (50) begin @(negedge clk); if (m_if.cmd_req) seen = 1'b1; end
    chk("no_req_before_init", 32'(seen), 32'd0);
    init_done = 1'b1;
    issue(2, 2, 1'b0, t, a, l);
    chk("init_type", 32'(t), 32'd1);
    chk("init_addr", 32'(a), 32'h0);
    chk("init_len",  32'(l), 32'd256);

    // alternation with both paths eligible
    rd_enable = 1'b1; rd_fifo_used = '0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      issue(3, 3, 1'b0, t, a, l);
      chk("alt_type", 32'(t), (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("alt_addr", 32'(a), 32'((i / 2) * 256));
    end

    // refresh priority and overrun, on the short-period instance
    rst = 1'b1;
    sel = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    issue(3, 30, 1'b0, t, a, l);
    chk("ref_first_type", 32'(t), 32'd1);
    chk("ref_no_ovr_yet", 32'(ovr_r), 32'd0);
    issue(45, 2, 1'b0, t, a, l);
    chk("ref_type", 32'(t), 32'd0);
    chk("ref_len",  32'(l), 32'd0);
    chk("ref_ovr",  32'(ovr_r), 32'd1);
    issue(2, 2, 1'b0, t, a, l);
    chk("ref_then_read", 32'(t), 32'd2);
    chk("ref_ovr_sticky", 32'(ovr_r), 32'd1);
    chk("ref_no_frame", 32'({fw_r, fr_r}), 32'd0);
    rst2 = 1'b1;
    sel  = 1'b0;

    // write threshold boundary and frame wrap
    rd_enable = 1'b0;
    wr_addr = 22'h100000; wr_max_addr = 22'h100200; wr_fifo_used = 11'd255;
    do_reset();
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (m_if.cmd_req) seen = 1'b1; end
    chk("wr_255_idle", 32'(seen), 32'd0);
    wr_fifo_used = 11'd256;
    base = fw_cnt;
    issue(2, 2, 1'b0, t, a, l);
    chk("wrap_a1", 32'(a), 32'h100000);
    issue(2, 2, 1'b0, t, a, l);
    chk("wrap_a2", 32'(a), 32'h100100);
    issue(2, 2, 1'b0, t, a, l);
    chk("wrap_a3", 32'(a), 32'h100000);
    chk("wrap_pulses", 32'(fw_cnt - base), 32'd1);

    // read threshold boundary, deferred load, idle load
    wr_fifo_used = '0; wr_addr = '0; wr_max_addr = 22'h100000;
    rd_addr = 22'h200000; rd_max_addr = 22'h300000;
    rd_enable = 1'b1; rd_fifo_used = 11'd769;
    do_reset();
    seen = 1'b0;
    repeat (10) begin @(negedge clk); if (m_if.cmd_req) seen = 1'b1; end
    chk("rd_769_idle", 32'(seen), 32'd0);
    rd_fifo_used = 11'd768;
    base = fr_cnt;
    issue(2, 2, 1'b0, t, a, l);
    chk("rd_type", 32'(t), 32'd2);
    chk("rd_a1", 32'(a), 32'h200000);
    issue(2, 4, 1'b1, t, a, l);
    chk("rd_a2", 32'(a), 32'h200100);
    issue(2, 0, 1'b0, t, a, l);
    rd_enable = 1'b0;
    chk("rd_deferred", 32'(a), 32'h200000);
    @(negedge clk);
    chk("rd_no_frame", 32'(fr_cnt - base), 32'd0);
    rd_addr = 22'h200400;
    rd_load = 1'b1;
    @(negedge clk);
    rd_load = 1'b0;
    rd_enable = 1'b1;
    issue(2, 2, 1'b0, t, a, l);
    chk("rd_idle_load", 32'(a), 32'h200400);

    // reset in BUSY, then a stray done
    rd_enable = 1'b0;
    wr_addr = 22'h000300; wr_max_addr = 22'h000400; wr_fifo_used = 11'd300;
    do_reset();
    begin
      int w = 0;
      while (!m_if.cmd_req && w < 50) begin @(negedge clk); w++; end
    end
    chk("mid_req", 32'(m_if.cmd_req), 32'd1);
    eng_ack = 1'b1; @(negedge clk); eng_ack = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_req",  32'(m_if.cmd_req),  32'd0);
    chk("mid_rst_type", 32'(m_if.cmd_type), 32'd0);
    chk("mid_rst_addr", 32'(m_if.cmd_addr), 32'd0);
    chk("mid_rst_len",  32'(m_if.cmd_len),  32'd0);
    base = fw_cnt;
    rst = 1'b0;
    eng_done = 1'b1;
    @(negedge clk);
    eng_done = 1'b0;
    @(negedge clk);
    chk("stray_no_frame", 32'(fw_cnt - base), 32'd0);
    issue(2, 2, 1'b0, t, a, l);
    chk("stray_addr", 32'(a), 32'h000300);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sdram_rw_arbiter.md
SDRAM_RW_ARBITER -- requirements
Module: sdram_rw_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 22: SDRAM word address width ({bank[1:0], 20-bit offset}).
REQ-002 SHALL have parameter LEN_W, default 9: burst length width.
REQ-003 SHALL have parameter LVL_W, default 11: FIFO fill-level width.
REQ-004 SHALL have parameter RD_FIFO_DEPTH, default 1024: read FIFO capacity in words.
REQ-005 SHALL have parameter REF_PERIOD, default 780: clk cycles between refresh requests.
REQ-006 SHALL have clk  in  1  sole clock (SDRAM controller domain); all logic on its rising edge.
REQ-007 SHALL have rst  in  1  synchronous, active-high reset.
REQ-008 SHALL have init_done  in  1  SDRAM power-up init complete.
REQ-009 SHALL have wr_len, rd_len  in  LEN_W each  write/read burst lengths in words, 1..256.
REQ-010 SHALL have wr_addr, wr_max_addr  in  ADDR_W each  write frame start and end-exclusive address.
REQ-011 SHALL have rd_addr, rd_max_addr  in  ADDR_W each  read frame start and end-exclusive address.
REQ-012 SHALL have wr_load, rd_load  in  1 each  pulse: reload that pointer from its start address.
REQ-013 SHALL have wr_fifo_used, rd_fifo_used  in  LVL_W each  write-FIFO words available, read-FIFO words held.
REQ-014 SHALL have rd_enable  in  1  display active; read bursts permitted.
REQ-015 SHALL have cmd_req  out  1, cmd_type  out  2 (0 refresh, 1 write, 2 read), cmd_addr  out  ADDR_W, cmd_len  out  LEN_W  command to the SDRAM command engine.
REQ-016 SHALL have cmd_ack  in  1  one-cycle pulse, command accepted; cmd_done  in  1  one-cycle pulse, command finished.
REQ-017 SHALL have frame_write_done, frame_read_done  out  1 each  one-cycle frame-wrap pulses; ref_overrun  out  1  sticky refresh-miss flag.

Function
REQ-018 SHALL implement FSM states INIT, IDLE, ISSUE, BUSY; INIT->IDLE on the first cycle with init_done=1.
REQ-019 SHALL, in IDLE, grant by priority: refresh pending > write/read; move to ISSUE the next cycle with cmd_req=1 and type/addr/len registered.
REQ-020 SHALL treat a write as eligible when wr_fifo_used >= wr_len, and a read as eligible when rd_enable=1 and rd_fifo_used <= RD_FIFO_DEPTH - rd_len.
REQ-021 SHALL, when write and read are both eligible, grant the type not granted last (last_rw flag, reset to read so write wins first).
REQ-022 SHALL hold cmd_req and all cmd_* stable in ISSUE until cmd_ack, then deassert cmd_req the cycle after and enter BUSY.
REQ-023 SHALL, in BUSY, return to IDLE on cmd_done; cmd_done arriving in the same cycle as cmd_ack SHALL be honoured (ISSUE->IDLE directly).
REQ-024 SHALL drive cmd_len=0 for refresh commands.
REQ-025 SHALL run a refresh counter 0..REF_PERIOD-1 from leaving INIT; on wrap set ref_pending; clear it when the refresh cmd_ack is received.
REQ-026 SHALL set ref_overrun when the counter wraps while ref_pending=1; it clears only on rst.
REQ-027 SHALL, on write/read completion, advance the pointer: ptr += len (ADDR_W wrap-free); if result >= max_addr, load start address and pulse frame_*_done for exactly one cycle.
REQ-028 SHALL apply wr_load/rd_load at once if that path has no command in ISSUE/BUSY; otherwise latch it and apply at completion, overriding the increment and suppressing frame_*_done.
REQ-029 SHALL use the pointer sampled at grant time for cmd_addr; start/max address changes mid-burst affect only later grants.

Reset
REQ-030 SHALL on rst: state=INIT, cmd_req=0, cmd_type=0, cmd_addr=0, cmd_len=0, frame pulses=0, ref_overrun=0, ref_pending=0, refresh counter=0, last_rw=read, pointers=wr_addr/rd_addr, pending loads cleared; reset mid-command abandons it with no done pulses.

Structure
REQ-031 SHALL place cmd_type encodings and FSM state encodings in shared package sdram_pkg.
REQ-032 SHALL instantiate one sub-module, sdram_addr_ptr, per path (pointer, wrap, deferred load, frame pulse).

Verification
REQ-033 Init: init_done low 50 cycles, wr_fifo_used=300 -> no cmd_req until init_done=1; first grant is a write to 0x000000, len 256.
REQ-034 Arbitration: both eligible, ack/done each after 3 cycles -> grants alternate W,R,W,R; addrs 0,256,512 per path.
REQ-035 Refresh: REF_PERIOD=20, both eligible -> refresh (type 0, len 0) issued at the next IDLE ahead of R/W; engine stalls ack 45 cycles -> ref_overrun=1, sticky.
REQ-036 Frame wrap: wr_addr=0x100000, wr_max_addr=0x100200, wr_len=256 -> second completion pulses frame_write_done once; next cmd_addr=0x100000.
REQ-037 Deferred load: rd_load during read BUSY at ptr 0x200100 -> after cmd_done ptr=rd_addr, no frame_read_done; rd_load while idle applies next cycle.
REQ-038 Reset mid-op: rst asserted in BUSY -> all outputs at reset values next cycle; stray cmd_done after reset is ignored.
